// File: rtl/alu_result_buffer.sv
// Result FIFO behind the 4-bit ALU: stores {sel, out, carry, zero} and serves them over valid/ready.
// Define ALU_RESBUF_STATS_EN to add saturating carry/zero/drop counters.
module alu_result_buffer #(
    parameter int DATA_W = 4,
    parameter int SEL_W  = 3,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SEL_W-1:0]           in_sel,
    input  logic [DATA_W-1:0]          in_out,
    input  logic                       in_carry,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SEL_W-1:0]           out_sel,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_carry,
    output logic                       out_zero,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       ovf_clr
`ifdef ALU_RESBUF_STATS_EN
    ,
    output logic [7:0]                 carry_cnt,
    output logic [7:0]                 zero_cnt,
    output logic [7:0]                 drop_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
        logic              carry;
        logic              zero;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             wr_entry;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               full, empty, push, pop, refused;

    // Handshake flags come only from registered count, so out_ready never reaches in_ready.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign refused   = in_valid && !in_ready;

    always_comb begin
        wr_entry = '{sel: in_sel, data: in_out, carry: in_carry, zero: (in_out == '0)};
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
        if (refused)      ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: contents are only observed behind out_valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign out_sel   = mem_q[rd_ptr_q].sel;
    assign out_data  = mem_q[rd_ptr_q].data;
    assign out_carry = mem_q[rd_ptr_q].carry;
    assign out_zero  = mem_q[rd_ptr_q].zero;
    assign count     = count_q;
    assign overflow  = ovf_q;

`ifdef ALU_RESBUF_STATS_EN
    logic [7:0] carry_cnt_q, carry_cnt_d;
    logic [7:0] zero_cnt_q, zero_cnt_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        carry_cnt_d = carry_cnt_q;
        zero_cnt_d  = zero_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (push && in_carry && carry_cnt_q != 8'hFF)      carry_cnt_d = carry_cnt_q + 8'd1;
        if (push && wr_entry.zero && zero_cnt_q != 8'hFF)  zero_cnt_d  = zero_cnt_q + 8'd1;
        // A drop in the same cycle as a clear still counts.
        if (refused) begin
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (ovf_clr) begin
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_cnt_q <= 8'd0;
            zero_cnt_q  <= 8'd0;
            drop_cnt_q  <= 8'd0;
        end else begin
            carry_cnt_q <= carry_cnt_d;
            zero_cnt_q  <= zero_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign carry_cnt = carry_cnt_q;
    assign zero_cnt  = zero_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed self-checking bench for alu_result_buffer (DEPTH=4).
module tb_alu_result_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_carry;
    logic [2:0] in_sel;
    logic [3:0] in_out;
    logic       out_valid, out_ready, out_carry, out_zero;
    logic [2:0] out_sel;
    logic [3:0] out_data;
    logic [2:0] count;
    logic       overflow, ovf_clr;
`ifdef ALU_RESBUF_STATS_EN
    logic [7:0] carry_cnt, zero_cnt, drop_cnt;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    alu_result_buffer #(.DATA_W(4), .SEL_W(3), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_out(in_out), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
        .out_data(out_data), .out_carry(out_carry), .out_zero(out_zero),
        .count(count), .overflow(overflow), .ovf_clr(ovf_clr)
`ifdef ALU_RESBUF_STATS_EN
        , .carry_cnt(carry_cnt), .zero_cnt(zero_cnt), .drop_cnt(drop_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [3:0] d, input logic c);
        in_valid = v; in_sel = s; in_out = d; in_carry = c;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 3'd0, 4'd0, 1'b0);
        out_ready = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        vectors++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
`ifdef ALU_RESBUF_STATS_EN
        vectors++; if ({carry_cnt, zero_cnt, drop_cnt} !== 24'd0) begin errors++; $display("FAIL reset_stats got %0d/%0d/%0d want 0/0/0", carry_cnt, zero_cnt, drop_cnt); end
`endif
    endtask

    task automatic test_single();
        drive(1'b1, 3'b000, 4'b0100, 1'b0);
        // No same-cycle bypass while empty.
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %b want 0", out_valid); end
        tick();
        drive(1'b0, 3'd0, 4'd0, 1'b0);
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b want 1", out_valid); end
        vectors++; if (out_data !== 4'b0100) begin errors++; $display("FAIL single_out_data got %b want 0100", out_data); end
        vectors++; if (out_sel !== 3'b000) begin errors++; $display("FAIL single_out_sel got %b want 000", out_sel); end
        vectors++; if (out_zero !== 1'b0) begin errors++; $display("FAIL single_out_zero got %b want 0", out_zero); end
        vectors++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
        tick();
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_hold got %b want 1", out_valid); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got %b want 0", out_valid); end
        vectors++; if (count !== 3'd0) begin errors++; $display("FAIL single_pop_count got %0d want 0", count); end
    endtask

    task automatic test_fill_overflow();
        logic [3:0] dv [4];
        logic       cv [4];
        dv[0] = 4'b0100; dv[1] = 4'b0011; dv[2] = 4'b1000; dv[3] = 4'b0000;
        cv[0] = 1'b0; cv[1] = 1'b0; cv[2] = 1'b0; cv[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready[%0d] got %b want 1", i, in_ready); end
            drive(1'b1, 3'(i + 1), dv[i], cv[i]);
            tick();
        end
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_in_ready got %b want 0", in_ready); end
        vectors++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", count); end
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got %b want 0", overflow); end
        drive(1'b1, 3'd7, 4'b1111, 1'b1);
        tick();
        drive(1'b0, 3'd0, 4'd0, 1'b0);
        vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b want 1", overflow); end
        vectors++; if (count !== 3'd4) begin errors++; $display("FAIL fill_ovf_count got %0d want 4", count); end
`ifdef ALU_RESBUF_STATS_EN
        vectors++; if ({carry_cnt, zero_cnt, drop_cnt} !== {8'd1, 8'd1, 8'd1}) begin errors++; $display("FAIL fill_stats got %0d/%0d/%0d want 1/1/1", carry_cnt, zero_cnt, drop_cnt); end
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got %b want 1", i, out_valid); end
            vectors++; if ({out_sel, out_data, out_carry, out_zero} !== {3'(i + 1), dv[i], cv[i], (i == 3)})
                begin errors++; $display("FAIL drain_entry[%0d] got %b %b %b %b want %b %b %b %b", i, out_sel, out_data, out_carry, out_zero, 3'(i + 1), dv[i], cv[i], (i == 3)); end
            tick();
        end
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", out_valid); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", overflow); end
`ifdef ALU_RESBUF_STATS_EN
        vectors++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL drop_clr got %0d want 0", drop_cnt); end
`endif
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'(i), 4'(i + 3), 1'b0);
            tick();
            vectors++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count[%0d] got %0d want 1", i, count); end
            vectors++; if (out_data !== 4'(i + 3) || out_sel !== 3'(i))
                begin errors++; $display("FAIL b2b_head[%0d] got %0d/%0d want %0d/%0d", i, out_sel, out_data, 3'(i), 4'(i + 3)); end
        end
        drive(1'b0, 3'd0, 4'd0, 1'b0);
        tick();
        out_ready = 1'b0;
        vectors++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_final_count got %0d want 0", count); end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd2, 4'(4'hA + i), 1'b0);
            tick();
        end
        // Pop, refused push and clear all in one cycle: set wins over clear.
        drive(1'b1, 3'd5, 4'h9, 1'b0);
        out_ready = 1'b1; ovf_clr = 1'b1;
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_in_ready got %b want 0", in_ready); end
        tick();
        out_ready = 1'b0; ovf_clr = 1'b0;
        vectors++; if (count !== 3'd3) begin errors++; $display("FAIL fullpop_count got %0d want 3", count); end
        vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL fullpop_overflow got %b want 1", overflow); end
        vectors++; if (out_data !== 4'hB) begin errors++; $display("FAIL fullpop_head got %h want b", out_data); end
`ifdef ALU_RESBUF_STATS_EN
        vectors++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL fullpop_drop got %0d want 1", drop_cnt); end
`endif
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_reaccept got %b want 1", in_ready); end
        tick();
        drive(1'b0, 3'd0, 4'd0, 1'b0);
        vectors++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_push_count got %0d want 4", count); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;
        vectors++; if (count !== 3'd2) begin errors++; $display("FAIL arst_pre_count got %0d want 2", count); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
        vectors++; if (count !== 3'd0) begin errors++; $display("FAIL arst_count got %0d want 0", count); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready got %b want 1", in_ready); end
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL arst_overflow got %b want 0", overflow); end
`ifdef ALU_RESBUF_STATS_EN
        vectors++; if ({carry_cnt, zero_cnt, drop_cnt} !== 24'd0) begin errors++; $display("FAIL arst_stats got %0d/%0d/%0d want 0/0/0", carry_cnt, zero_cnt, drop_cnt); end
`endif
        #2 rst = 1'b0;
        drive(1'b1, 3'd6, 4'h5, 1'b1);
        tick();
        drive(1'b0, 3'd0, 4'd0, 1'b0);
        vectors++; if ({out_valid, out_sel, out_data, out_carry} !== {1'b1, 3'd6, 4'h5, 1'b1})
            begin errors++; $display("FAIL arst_new_push got %b %b %h %b want 1 110 5 1", out_valid, out_sel, out_data, out_carry); end
        vectors++; if (count !== 3'd1) begin errors++; $display("FAIL arst_new_count got %0d want 1", count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_back_to_back();
        test_full_pop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the 4-bit ALU: captures each ALU result (out, carry) and its opcode (sel) into a small synchronous FIFO.
- Derives a zero flag per entry.
- Presents entries to the consumer over a valid/ready handshake.
- Keeps a sticky overflow flag, so the ALU side can run free without silently losing results.

Parameters:
- DATA_W, 4, width of ALU result (matches ALU out).
- SEL_W, 3, width of ALU opcode (matches ALU sel).
- DEPTH, 4, FIFO entries; power of two, >= 2; pointer width = $clog2(DEPTH).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ALU result on in_* is valid this cycle.
- in_ready  output  1  buffer can accept; combinational = !full.
- in_sel  input  SEL_W  opcode that produced the result.
- in_out  input  DATA_W  ALU result value.
- in_carry  input  1  ALU carry/borrow.
- out_valid  output  1  head entry valid; = !empty.
- out_ready  input  1  consumer accepts head entry.
- out_sel  output  SEL_W  head entry opcode.
- out_data  output  DATA_W  head entry result.
- out_carry  output  1  head entry carry.
- out_zero  output  1  head entry result == 0.
- count  output  $clog2(DEPTH)+1  entries currently stored.
- overflow  output  1  sticky: an in_valid arrived while full.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, asserted or mid-operation):
  - wr_ptr, rd_ptr and count go to 0; overflow goes to 0.
  - out_valid = 0 and in_ready = 1 immediately.
  - Stored data is discarded.
  - out_* data fields are don't-care while out_valid = 0.
  - Bench checks out_* only when out_valid = 1.
- Push: occurs when in_valid && in_ready.
  - Stores {in_sel, in_out, in_carry, (in_out == 0)} at wr_ptr.
  - wr_ptr increments modulo DEPTH (natural wrap).
- Pop: occurs when out_valid && out_ready; rd_ptr increments modulo DEPTH.
- Outputs out_* are a combinational read of the entry at rd_ptr (show-ahead).
- Latency: an entry pushed in cycle N is visible with out_valid = 1 in cycle N+1. There is no same-cycle bypass when empty.
- count update per cycle:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
  - Range 0..DEPTH.
- Boundary cases:
  - Full (count == DEPTH): in_ready = 0; in_valid is ignored (no write, pointers unchanged) and sets overflow. Pop in the same cycle is allowed; the push is still refused that cycle, because in_ready is derived from registered count.
  - Empty (count == 0): out_valid = 0; out_ready is ignored; pointers unchanged.
  - Simultaneous push and pop with 0 < count < DEPTH: both take effect; count is unchanged.
- Overflow:
  - Set on any cycle with in_valid && !in_ready.
  - Cleared by ovf_clr.
  - If set and clear occur in the same cycle, set wins.
- No combinational path from out_ready to in_ready.

Optional Feature:
- Macro: ALU_RESBUF_STATS_EN.
- When defined, adds three outputs:
  - carry_cnt, 8 bits: increments on each push with in_carry = 1.
  - zero_cnt, 8 bits: increments on each push with in_out == 0.
  - drop_cnt, 8 bits: increments on each refused in_valid.
- Counter rules:
  - All three saturate at 255.
  - All reset to 0 on rst.
  - drop_cnt is also cleared by ovf_clr; same-cycle increment wins.
- When not defined: the ports and logic are absent; the block is otherwise identical.

Test Plan:
- Reset then idle -> out_valid = 0, in_ready = 1, count = 0, overflow = 0.
- Single push sel=000, out=0100, carry=0 in cycle N, out_ready = 0 -> cycle N+1: out_valid = 1, out_data = 0100, out_zero = 0, count = 1. Assert out_ready -> next cycle out_valid = 0.
- Push DEPTH=4 results (0100, 0011, 1000, 0000 with carry 0,0,0,1) with out_ready = 0:
  - in_ready drops after the 4th push; count = 4.
  - A 5th in_valid sets overflow = 1 and is not stored.
  - Drain returns the four entries in order; the last has out_zero = 1, out_carry = 1.
- Continuous push and pop, out_ready = 1, 10 entries -> count stays 1 after the first push; pointers wrap twice; output order matches input order.
- Full with pop and in_valid in the same cycle -> pop occurs, push refused, overflow set, count = 3. Next cycle the push is accepted.
- Async rst asserted mid-stream at count = 2 -> out_valid = 0 and count = 0 before the next clock edge; after release the first new push appears one cycle later. With ALU_RESBUF_STATS_EN defined, carry_cnt/zero_cnt/drop_cnt read 0 after reset and 1/1/1 after the fill/overflow scenario.
